vga_timing_controller: RTL and testbench

- Drives the 640x480@60 VGA raster. Generates pixelX/pixelY for every drawing block (background, objects) and consumes their returned 8-bit RGB332 colour.
- Produces the DAC RGB/sync/blank outputs, delayed so that sync, blank and colour stay pixel-aligned despite the drawers' registered latency.
- Sits between the drawing/mux layer and the board VGA DAC pins.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_pipe_delay.sv | 31 +++
 rtl/vga_timing_controller.sv | 98 +++++++++
 tb/tb_vga_timing_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the RGB332 pixel type and the colour expansion helpers.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W        = 11;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Bit replication spreads the short code evenly over the full 8-bit DAC range.
    function automatic logic [7:0] expand3to8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2to8(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// DEPTH x WIDTH shift register with asynchronous clear; DEPTH of 0 is a straight wire.
module vga_pipe_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_controller.sv
// 640x480@60 raster generator: pixel counters, sync/blank decode and DAC output stage
// delayed to line up with the drawers' registered colour.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE     = H_ACTIVE_DEF,
    parameter int   H_FP         = H_FP_DEF,
    parameter int   H_SYNC       = H_SYNC_DEF,
    parameter int   H_BP         = H_BP_DEF,
    parameter int   V_ACTIVE     = V_ACTIVE_DEF,
    parameter int   V_FP         = V_FP_DEF,
    parameter int   V_SYNC       = V_SYNC_DEF,
    parameter int   V_BP         = V_BP_DEF,
    parameter int   DRAW_LATENCY = 1,
    parameter logic SYNC_ACTIVE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       RGB_in,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             startOfFrame,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_BLANK_N,
    output logic [7:0]       oVGA_R,
    output logic [7:0]       oVGA_G,
    output logic [7:0]       oVGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic    hs0, vs0, vis0;
    logic    hs_d, vs_d, vis_d;
    rgb332_t rgb;

    assign rgb = rgb332_t'(RGB_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (pixelX == H_MAX) begin
            pixelX <= '0;
            pixelY <= (pixelY == V_MAX) ? '0 : pixelY + 1'b1;
        end else begin
            pixelX <= pixelX + 1'b1;
        end
    end

    always_comb begin
        hs0  = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
        vs0  = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);
        vis0 = (pixelX < H_ACT_C) && (pixelY < V_ACT_C);
    end

    // Timing flags wait here for as long as the drawers take to return colour.
    vga_pipe_delay #(
        .DEPTH (DRAW_LATENCY),
        .WIDTH (3)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({hs0, vs0, vis0}),
        .dout  ({hs_d, vs_d, vis_d})
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            startOfFrame <= 1'b0;
            oVGA_HS      <= ~SYNC_ACTIVE;
            oVGA_VS      <= ~SYNC_ACTIVE;
            oVGA_BLANK_N <= 1'b0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
        end else begin
            startOfFrame <= (pixelX == '0) && (pixelY == V_ACT_C);
            oVGA_HS      <= hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            oVGA_VS      <= vs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            oVGA_BLANK_N <= vis_d;
            oVGA_R       <= vis_d ? expand3to8(rgb.r) : 8'h00;
            oVGA_G       <= vis_d ? expand3to8(rgb.g) : 8'h00;
            oVGA_B       <= vis_d ? expand2to8(rgb.b) : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: full horizontal timing, shortened vertical
// timing (30 lines/frame) so that whole frames fit in a short run.
module tb_vga_timing_controller;

    localparam int V_ACT = 20;
    localparam int V_FP  = 3;
    localparam int V_SY  = 2;
    localparam int V_BP  = 5;
    localparam int FRAME = 800 * (V_ACT + V_FP + V_SY + V_BP);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  RGB_in;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, oVGA_HS, oVGA_VS, oVGA_BLANK_N;
    logic [7:0]  oVGA_R, oVGA_G, oVGA_B;

    logic        rgb_mode = 1'b0;
    logic [7:0]  rgb_const = 8'h00;
    logic [7:0]  drawer_q;
    int          cyc = 0;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        drawer_q <= pixelX[7:0];
    end

    assign RGB_in = rgb_mode ? rgb_const : drawer_q;

    vga_timing_controller #(
        .V_ACTIVE     (V_ACT),
        .V_FP         (V_FP),
        .V_SYNC       (V_SY),
        .V_BP         (V_BP),
        .DRAW_LATENCY (1),
        .SYNC_ACTIVE  (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RGB_in       (RGB_in),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .oVGA_HS      (oVGA_HS),
        .oVGA_VS      (oVGA_VS),
        .oVGA_BLANK_N (oVGA_BLANK_N),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return oVGA_HS;
            1:       return oVGA_VS;
            2:       return oVGA_BLANK_N;
            default: return startOfFrame;
        endcase
    endfunction

    task automatic wait_xy(input string tag, input int x, input int y, input int limit);
        int n = 0;
        while (!(pixelX == 11'(x) && pixelY == 11'(y)) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_x"}, 32'(pixelX), 32'(x));
        check({tag, "_y"}, 32'(pixelY), 32'(y));
    endtask

    task automatic wait_sig(input string tag, input int which, input logic level, input int limit);
        int n = 0;
        while (sig(which) !== level && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(sig(which)), 32'(level));
    endtask

    task automatic count_low(input int which, input int limit, output int n);
        n = 0;
        while (sig(which) == 1'b0 && n < limit) begin
            step();
            n++;
        end
    endtask

    int          t0, t1, t_sof, n, k, bad;
    int          idx_t [8] = '{0, 1, 2, 28, 73, 146, 224, 255};
    logic [23:0] exp_t [8] = '{24'h000000, 24'h000055, 24'h0000AA, 24'h00FF00,
                               24'h494955, 24'h9292AA, 24'hFF0000, 24'hFFFFFF};

    initial begin
        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        step();
        check("rst_x", 32'(pixelX), 0);
        check("rst_y", 32'(pixelY), 0);
        check("rst_hs", 32'(oVGA_HS), 1);
        check("rst_vs", 32'(oVGA_VS), 1);
        check("rst_blank", 32'(oVGA_BLANK_N), 0);
        check("rst_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 0);
        check("rst_sof", 32'(startOfFrame), 0);

        reset = 1'b0;
        step(); check("run_x1", 32'(pixelX), 1);
        step(); check("run_x2", 32'(pixelX), 2);
        step(); check("run_x3", 32'(pixelX), 3);

        // Horizontal sync placement, width and line period.
        wait_xy("hs_start", 656, 0, 900);
        check("hs_before", 32'(oVGA_HS), 1);
        t0 = cyc;
        wait_sig("hs_fall", 0, 1'b0, 10);
        check("hs_latency", 32'(cyc - t0), 2);
        t1 = cyc;
        count_low(0, 200, n);
        check("hs_width", 32'(n), 96);
        wait_sig("hs_fall2", 0, 1'b0, 900);
        check("line_period", 32'(cyc - t1), 800);

        // Colour expansion with a drawer that echoes pixelX one clock late.
        wait_sig("blank_lo", 2, 1'b0, 900);
        wait_sig("blank_hi", 2, 1'b1, 900);
        k = 0;
        for (int i = 0; i < 256; i++) begin
            if (k < 8 && i == idx_t[k]) begin
                check($sformatf("echo_px%0d", i), 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(exp_t[k]));
                k++;
            end
            step();
        end
        check("echo_blank", 32'(oVGA_BLANK_N), 1);

        rgb_const = 8'hFF;
        rgb_mode  = 1'b1;
        repeat (3) step();
        check("const_ff", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h00FFFFFF);

        // Outputs for pixelX 643..792 must be fully blanked despite a white drawer.
        wait_xy("hblank", 645, 2, 900);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (oVGA_BLANK_N !== 1'b0 || {oVGA_R, oVGA_G, oVGA_B} !== 24'h0) bad++;
            step();
        end
        check("hblank_zero", 32'(bad), 0);

        rgb_const = 8'h02;
        wait_xy("const02", 20, 3, 900);
        check("const_02", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h000000AA);
        rgb_mode = 1'b0;

        // Start-of-frame pulse, vertical sync and frame period.
        wait_xy("sof_pos", 0, V_ACT, FRAME);
        check("sof_pre", 32'(startOfFrame), 0);
        step();
        check("sof_pulse", 32'(startOfFrame), 1);
        t_sof = cyc;
        step();
        check("sof_post", 32'(startOfFrame), 0);

        wait_xy("vs_start", 0, V_ACT + V_FP, 4000);
        check("vs_before", 32'(oVGA_VS), 1);
        t0 = cyc;
        wait_sig("vs_fall", 1, 1'b0, 10);
        check("vs_latency", 32'(cyc - t0), 2);
        count_low(1, 1700, n);
        check("vs_width", 32'(n), 1600);

        wait_sig("sof_next", 3, 1'b1, FRAME + 10);
        check("frame_period", 32'(cyc - t_sof), FRAME);

        // Asynchronous reset while both syncs are active.
        wait_xy("mid", 700, V_ACT + V_FP, 4000);
        check("mid_hs", 32'(oVGA_HS), 0);
        check("mid_vs", 32'(oVGA_VS), 0);
        reset = 1'b1;
        #1;
        check("arst_hs", 32'(oVGA_HS), 1);
        check("arst_vs", 32'(oVGA_VS), 1);
        check("arst_x", 32'(pixelX), 0);
        check("arst_y", 32'(pixelY), 0);
        check("arst_blank", 32'(oVGA_BLANK_N), 0);
        repeat (2) @(posedge clk);
        step();
        check("arst_hold", 32'(pixelX), 0);
        reset = 1'b0;
        step();
        check("restart_x", 32'(pixelX), 1);
        check("restart_y", 32'(pixelY), 0);

        wait_xy("re_hs", 656, 0, 900);
        check("re_hs_before", 32'(oVGA_HS), 1);
        t0 = cyc;
        wait_sig("re_hs_fall", 0, 1'b0, 10);
        check("re_hs_latency", 32'(cyc - t0), 2);
        count_low(0, 200, n);
        check("re_hs_width", 32'(n), 96);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
